// File: rtl/pc_pkg.sv
// Shared types and constants for the PC/fetch sequencer.
//   fetch_state_e   : fetch FSM encoding (BOOT, REQ, EXEC, TRAP)
//   PC_INC          : program-counter increment
//   PC_RESET_VECTOR : default PC after reset
//   PC_TRAP_VECTOR  : default PC loaded on a misaligned target (PC_MISALIGN_TRAP_EN)
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        TRAP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INC          = 32'd4;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0100;
    localparam logic [31:0] PC_ALIGN_MASK   = 32'hFFFF_FFFC;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Wrapping retired-instruction counter.
//   i_clk   : rising-edge clock
//   i_rst   : synchronous active-high clear
//   i_en    : increment strobe (one per retired instruction)
//   o_count : current count, wraps modulo 2^WIDTH
module retire_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + WIDTH'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer, sits downstream of mux_pc.
// Holds the architectural PC, issues one imem request per instruction and
// commits next_pc when the datapath retires.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : misaligned retire target redirects to TRAP_VECTOR, records
//               bad_addr and pulses misalign_trap for one cycle (TRAP state).
//   undefined : low two bits of the target are cleared; trap outputs tied 0.
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst           synchronous active-high reset (highest priority)
//   i_next_pc       next PC selected by mux_pc
//   i_stall         datapath hold, blocks PC commit while high
//   i_imem_ready    imem accepts/returns current request (used in REQ only)
//   o_imem_req      fetch request, held until imem_ready
//   o_imem_addr     fetch address (== pc)
//   o_instr_valid   fetched instruction valid for execution this cycle
//   o_pc            current PC
//   o_pc_plus4      pc + 4, combinational, back to mux_pc
//   o_instret       retired-instruction count
//   o_misalign_trap one-cycle pulse on misaligned target
//   o_bad_addr      last offending next_pc
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR
`ifdef PC_MISALIGN_TRAP_EN
   ,parameter logic [31:0] TRAP_VECTOR  = PC_TRAP_VECTOR
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_next_pc,
    input  logic        i_stall,
    input  logic        i_imem_ready,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instret,
    output logic        o_misalign_trap,
    output logic [31:0] o_bad_addr
);

    fetch_state_e r_state, w_next_state;
    logic [31:0]  r_pc;
    logic         w_retire;

    // One retire per EXEC visit: leaving EXEC is the retire event itself.
    assign w_retire = (r_state == EXEC) && !i_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= BOOT;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT: w_next_state = REQ;
            REQ:  if (i_imem_ready) w_next_state = EXEC;
            EXEC: begin
                if (!i_stall) begin
`ifdef PC_MISALIGN_TRAP_EN
                    w_next_state = is_misaligned(i_next_pc) ? TRAP : REQ;
`else
                    w_next_state = REQ;
`endif
                end
            end
            TRAP: w_next_state = REQ;
            default: w_next_state = BOOT;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic [31:0] r_bad_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_VECTOR;
            r_bad_addr <= '0;
        end else if (w_retire) begin
            if (is_misaligned(i_next_pc)) begin
                r_pc       <= TRAP_VECTOR;
                r_bad_addr <= i_next_pc;
            end else begin
                r_pc       <= i_next_pc;
            end
        end
    end

    assign o_misalign_trap = (r_state == TRAP);
    assign o_bad_addr      = r_bad_addr;
`else
    // Misaligned targets are silently word-aligned.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_pc <= RESET_VECTOR;
        else if (w_retire)
            r_pc <= i_next_pc & PC_ALIGN_MASK;
    end

    assign o_misalign_trap = 1'b0;
    assign o_bad_addr      = '0;
`endif

    retire_counter #(.WIDTH(32)) u_retire_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_retire),
        .o_count (o_instret)
    );

    // Request/valid decode straight from the state register: glitch-free and
    // held stable for as long as the FSM stays in the state.
    assign o_imem_req    = (r_state == REQ);
    assign o_imem_addr   = r_pc;
    assign o_instr_valid = (r_state == EXEC);
    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc + PC_INC;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl plus a narrow standalone
// retire_counter instance to exercise counter wrap in a few cycles.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        stall;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;
    logic        misalign_trap;
    logic [31:0] bad_addr;

    logic        c_clr;
    logic        c_en;
    logic [3:0]  c_count;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_next_pc       (next_pc),
        .i_stall         (stall),
        .i_imem_ready    (imem_ready),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .o_instr_valid   (instr_valid),
        .o_pc            (pc),
        .o_pc_plus4      (pc_plus4),
        .o_instret       (instret),
        .o_misalign_trap (misalign_trap),
        .o_bad_addr      (bad_addr)
    );

    retire_counter #(.WIDTH(4)) u_ctr4 (
        .i_clk   (clk),
        .i_rst   (c_clr),
        .i_en    (c_en),
        .o_count (c_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; next_pc = '0; stall = 1'b0; imem_ready = 1'b0;
        c_clr = 1'b1; c_en = 1'b0;

        // 1 reset
        tick(); tick();
        check("rst_pc",       pc,          32'h0);
        check("rst_req",      {31'b0, imem_req},    32'h0);
        check("rst_valid",    {31'b0, instr_valid}, 32'h0);
        check("rst_instret",  instret,     32'h0);
        check("rst_plus4",    pc_plus4,    32'h4);
        check("rst_trap",     {31'b0, misalign_trap}, 32'h0);
        check("rst_bad",      bad_addr,    32'h0);
        rst = 1'b0;
        tick();
        check("boot_req",     {31'b0, imem_req}, 32'h1);

        // 2 wait states
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_req",  {31'b0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, 32'h0);
            check("wait_valid", {31'b0, instr_valid}, 32'h0);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("exec_valid",   {31'b0, instr_valid}, 32'h1);
        check("exec_req",     {31'b0, imem_req},    32'h0);

        // 3 retire + stall
        next_pc = 32'd100; stall = 1'b1;
        imem_ready = 1'b1;  // ignored outside REQ
        tick(); tick();
        imem_ready = 1'b0;
        check("stall_pc",     pc, 32'h0);
        check("stall_valid",  {31'b0, instr_valid}, 32'h1);
        check("stall_instret", instret, 32'h0);
        stall = 1'b0;
        tick();
        check("ret_pc",       pc, 32'd100);
        check("ret_instret",  instret, 32'd1);
        check("ret_addr",     imem_addr, 32'd100);
        check("ret_req",      {31'b0, imem_req}, 32'h1);
        check("ret_valid",    {31'b0, instr_valid}, 32'h0);
        check("ret_plus4",    pc_plus4, 32'd104);

        // 4 misaligned target
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        next_pc = 32'd102;
        tick();
        check("mis_instret",  instret, 32'd2);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pc",       pc, 32'h100);
        check("mis_bad",      bad_addr, 32'd102);
        check("mis_trap",     {31'b0, misalign_trap}, 32'h1);
        check("mis_req",      {31'b0, imem_req}, 32'h0);
`else
        check("mis_pc",       pc, 32'd100);
        check("mis_trap",     {31'b0, misalign_trap}, 32'h0);
        check("mis_bad",      bad_addr, 32'h0);
        check("mis_req",      {31'b0, imem_req}, 32'h1);
`endif
        tick();
        check("mis_trap_end", {31'b0, misalign_trap}, 32'h0);
        check("mis_req2",     {31'b0, imem_req}, 32'h1);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_addr2",    imem_addr, 32'h100);
`else
        check("mis_addr2",    imem_addr, 32'd100);
`endif

        // 5 wrap of pc_plus4
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        next_pc = 32'hFFFF_FFFC;
        tick();
        check("wrap_pc",      pc, 32'hFFFF_FFFC);
        check("wrap_plus4",   pc_plus4, 32'h0);
        check("wrap_instret", instret, 32'd3);

        // counter wrap on a narrow instance
        tick();
        check("ctr_clr",      {28'b0, c_count}, 32'h0);
        c_clr = 1'b0; c_en = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("ctr_max",      {28'b0, c_count}, 32'hF);
        c_en = 1'b0;
        tick();
        check("ctr_hold",     {28'b0, c_count}, 32'hF);
        c_en = 1'b1;
        tick();
        check("ctr_wrap",     {28'b0, c_count}, 32'h0);
        c_en = 1'b0;

        // 6 reset collides with imem_ready in REQ
        check("coll_pre_req", {31'b0, imem_req}, 32'h1);
        rst = 1'b1; imem_ready = 1'b1;
        tick();
        check("coll_valid",   {31'b0, instr_valid}, 32'h0);
        check("coll_req",     {31'b0, imem_req}, 32'h0);
        check("coll_pc",      pc, 32'h0);
        check("coll_instret", instret, 32'h0);
        rst = 1'b0; imem_ready = 1'b0;
        tick();
        check("coll_valid2",  {31'b0, instr_valid}, 32'h0);
        check("coll_req2",    {31'b0, imem_req}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
